uart_fifo_module: RTL and testbench

Parametrised full-duplex UART with TX and RX FIFOs, configurable frame format, hardware flow control (cts_n/rts_n) and sticky error reporting.

- Replaces the single-register UART wrapper; sits between the PC serial pins and the keyboard/control logic.
- Lets the host queue up to FIFO_DEPTH words in each direction without per-byte handshaking.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_sync_fifo.sv | 54 +++++
 rtl/uart_fifo_module.sv | 249 ++++++++++++++++++++++++
 tb/tb_uart_fifo_module.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared parity codes, FSM encodings and parity helper for the UART
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Callers zero-extend narrower words; padding zeros do not change the XOR.
  function automatic logic parity_bit(input logic [8:0] word, input int ptype);
    logic p;
    p = 1'b0;
    if (ptype == PAR_ODD) p = ~^word;
    else if (ptype == PAR_EVEN) p = ^word;
    return p;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - first-word fall-through synchronous FIFO with occupancy output
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     n_rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A pop frees the slot the concurrent push writes into, so full+pop still accepts.
  assign do_pop  = rd_en_i && !empty_o;
  assign do_push = wr_en_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_fifo_module.sv
// rtl/uart_fifo_module.sv - full-duplex UART with TX/RX FIFOs, cts/rts flow control, sticky errors
module uart_fifo_module #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int BIT_LENGHT  = 8,
  parameter int PARITY_TYPE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic [BIT_LENGHT-1:0]         tx_data,
  input  logic                          tx_wr,
  output logic                          tx_full,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [BIT_LENGHT-1:0]         rx_data,
  input  logic                          rx_rd,
  output logic                          rx_empty,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  input  logic                          err_clr,
  output logic                          parity_error,
  output logic                          frame_error,
  output logic                          overrun,
  output logic                          busy_bit,
  input  logic                          cts_n,
  output logic                          rts_n,
  input  logic                          rx,
  output logic                          tx
);

  import uart_pkg::*;

  localparam int CPB  = CLK_FREQ / BAUD_RATE;
  localparam int CW   = $clog2(CPB);
  localparam int LW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
  localparam logic [3:0]    DATA_LAST = 4'(BIT_LENGHT - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [LW-1:0] RTS_LEVEL = LW'(FIFO_DEPTH - 2);
  localparam logic          HAS_PAR   = (PARITY_TYPE != PAR_NONE);

  logic [BIT_LENGHT-1:0] txf_data;
  logic                  txf_empty, tx_pop;
  logic                  rxf_full, rx_push;

  uart_sync_fifo #(.WIDTH(BIT_LENGHT), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i(clk), .n_rst_i(n_rst),
    .wr_en_i(tx_wr), .wr_data_i(tx_data),
    .rd_en_i(tx_pop), .rd_data_o(txf_data),
    .full_o(tx_full), .empty_o(txf_empty), .level_o(tx_level)
  );

  logic [2:0]            tx_state_q, tx_state_d;
  logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
  logic [3:0]            tx_bit_q, tx_bit_d;
  logic [BIT_LENGHT-1:0] tx_sh_q, tx_sh_d;
  logic                  tx_par_q, tx_par_d;
  logic                  tx_q, tx_d;

  // tx is registered alongside the state so each bit holds for exactly CPB cycles.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!txf_empty && !cts_n) begin
          tx_pop     = 1'b1;
          tx_sh_d    = txf_data;
          tx_par_d   = parity_bit(9'(txf_data), PARITY_TYPE);
          tx_cnt_d   = '0;
          tx_d       = 1'b0;
          tx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = tx_sh_q[0];
          tx_state_d = ST_DATA;
        end else tx_cnt_d = tx_cnt_q + 1'b1;
      end
      ST_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == DATA_LAST) begin
            tx_bit_d   = '0;
            tx_d       = HAS_PAR ? tx_par_q : 1'b1;
            tx_state_d = HAS_PAR ? ST_PARITY : ST_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
            tx_sh_d  = tx_sh_q >> 1;
            tx_d     = tx_sh_q[1];
          end
        end else tx_cnt_d = tx_cnt_q + 1'b1;
      end
      ST_PARITY: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = 1'b1;
          tx_state_d = ST_STOP;
        end else tx_cnt_d = tx_cnt_q + 1'b1;
      end
      ST_STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == STOP_LAST) tx_state_d = ST_IDLE;
          else tx_bit_d = tx_bit_q + 1'b1;
        end else tx_cnt_d = tx_cnt_q + 1'b1;
      end
      default: begin
        tx_d       = 1'b1;
        tx_state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
    end
  end

  assign tx       = tx_q;
  assign busy_bit = (tx_state_q != ST_IDLE);

  logic                  rx_meta_q, rx_sync_q;
  logic [2:0]            rx_state_q, rx_state_d;
  logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
  logic [3:0]            rx_bit_q, rx_bit_d;
  logic [BIT_LENGHT-1:0] rx_sh_q, rx_sh_d;
  logic                  rx_par_q, rx_par_d;
  logic                  stop_sample, par_bad, good_frame;
  logic                  frame_evt, par_evt, ovr_evt;
  logic                  perr_q, ferr_q, ovr_q, rts_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_par_d   = rx_par_q;
    case (rx_state_q)
      ST_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_sync_q) rx_state_d = ST_START;
      end
      ST_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
        end else rx_cnt_d = rx_cnt_q + 1'b1;
      end
      ST_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_sync_q, rx_sh_q[BIT_LENGHT-1:1]};
          if (rx_bit_q == DATA_LAST) rx_state_d = HAS_PAR ? ST_PARITY : ST_STOP;
          else rx_bit_d = rx_bit_q + 1'b1;
        end else rx_cnt_d = rx_cnt_q + 1'b1;
      end
      ST_PARITY: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_par_d   = rx_sync_q;
          rx_state_d = ST_STOP;
        end else rx_cnt_d = rx_cnt_q + 1'b1;
      end
      ST_STOP: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = ST_IDLE;
        end else rx_cnt_d = rx_cnt_q + 1'b1;
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // A pop in the same cycle makes room, so a full FIFO being read is not an overrun.
  assign stop_sample = (rx_state_q == ST_STOP) && (rx_cnt_q == CNT_LAST);
  assign par_bad     = HAS_PAR && (rx_par_q != parity_bit(9'(rx_sh_q), PARITY_TYPE));
  assign frame_evt   = stop_sample && !rx_sync_q;
  assign par_evt     = stop_sample && rx_sync_q && par_bad;
  assign good_frame  = stop_sample && rx_sync_q && !par_bad;
  assign ovr_evt     = good_frame && rxf_full && !rx_rd;
  assign rx_push     = good_frame && !ovr_evt;

  uart_sync_fifo #(.WIDTH(BIT_LENGHT), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i(clk), .n_rst_i(n_rst),
    .wr_en_i(rx_push), .wr_data_i(rx_sh_q),
    .rd_en_i(rx_rd), .rd_data_o(rx_data),
    .full_o(rxf_full), .empty_o(rx_empty), .level_o(rx_level)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_par_q   <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      rts_q      <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_par_q   <= rx_par_d;
      perr_q     <= par_evt   || (perr_q && !err_clr);
      ferr_q     <= frame_evt || (ferr_q && !err_clr);
      ovr_q      <= ovr_evt   || (ovr_q && !err_clr);
      rts_q      <= (rx_level >= RTS_LEVEL);
    end
  end

  assign parity_error = perr_q;
  assign frame_error  = ferr_q;
  assign overrun      = ovr_q;
  assign rts_n        = rts_q;

endmodule

// File: tb/tb_uart_fifo_module.sv
// tb/tb_uart_fifo_module.sv - directed table-driven bench for uart_fifo_module (8N1, 7E2 loopback, 8O1)
module tb_uart_fifo_module;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // DUT A: 8N1, depth 4, rx driven by bench
  logic       a_n_rst, a_tx_wr, a_tx_full, a_rx_rd, a_rx_empty, a_err_clr;
  logic       a_perr, a_ferr, a_ovr, a_busy, a_cts_n, a_rts_n, a_rx, a_tx;
  logic [7:0] a_tx_data, a_rx_data;
  logic [2:0] a_tx_level, a_rx_level;
  // DUT B: 7E2, depth 16, tx looped to rx
  logic       bc_n_rst;
  logic       b_tx_wr, b_tx_full, b_rx_rd, b_rx_empty, b_err_clr;
  logic       b_perr, b_ferr, b_ovr, b_busy, b_cts_n, b_rts_n, b_tx;
  logic [6:0] b_tx_data, b_rx_data;
  logic [4:0] b_tx_level, b_rx_level;
  // DUT C: 8O1, depth 4
  logic       c_tx_wr, c_tx_full, c_rx_rd, c_rx_empty, c_err_clr;
  logic       c_perr, c_ferr, c_ovr, c_busy, c_cts_n, c_rts_n, c_rx, c_tx;
  logic [7:0] c_tx_data, c_rx_data;
  logic [2:0] c_tx_level, c_rx_level;

  uart_fifo_module #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .BIT_LENGHT(8),
    .PARITY_TYPE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .n_rst(a_n_rst), .tx_data(a_tx_data), .tx_wr(a_tx_wr), .tx_full(a_tx_full),
    .tx_level(a_tx_level), .rx_data(a_rx_data), .rx_rd(a_rx_rd), .rx_empty(a_rx_empty),
    .rx_level(a_rx_level), .err_clr(a_err_clr), .parity_error(a_perr), .frame_error(a_ferr),
    .overrun(a_ovr), .busy_bit(a_busy), .cts_n(a_cts_n), .rts_n(a_rts_n), .rx(a_rx), .tx(a_tx));

  uart_fifo_module #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .BIT_LENGHT(7),
    .PARITY_TYPE(2), .STOP_BITS(2), .FIFO_DEPTH(16)) dut_b (
    .clk(clk), .n_rst(bc_n_rst), .tx_data(b_tx_data), .tx_wr(b_tx_wr), .tx_full(b_tx_full),
    .tx_level(b_tx_level), .rx_data(b_rx_data), .rx_rd(b_rx_rd), .rx_empty(b_rx_empty),
    .rx_level(b_rx_level), .err_clr(b_err_clr), .parity_error(b_perr), .frame_error(b_ferr),
    .overrun(b_ovr), .busy_bit(b_busy), .cts_n(b_cts_n), .rts_n(b_rts_n), .rx(b_tx), .tx(b_tx));

  uart_fifo_module #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .BIT_LENGHT(8),
    .PARITY_TYPE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .n_rst(bc_n_rst), .tx_data(c_tx_data), .tx_wr(c_tx_wr), .tx_full(c_tx_full),
    .tx_level(c_tx_level), .rx_data(c_rx_data), .rx_rd(c_rx_rd), .rx_empty(c_rx_empty),
    .rx_level(c_rx_level), .err_clr(c_err_clr), .parity_error(c_perr), .frame_error(c_ferr),
    .overrun(c_ovr), .busy_bit(c_busy), .cts_n(c_cts_n), .rts_n(c_rts_n), .rx(c_rx), .tx(c_tx));

  typedef struct {
    logic [7:0]  word;
    logic [15:0] bits;
  } tx_vec_t;

  typedef struct {
    logic [7:0] word;
    logic [2:0] level;
    logic       rts_n;
    logic       ovr;
  } rx_vec_t;

  tx_vec_t tx_tab[2];
  rx_vec_t rx_tab[5];
  logic [7:0] drain_tab[4];

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Serial bit k sampled at its middle; call right after the start-bit falling edge.
  task automatic check_frame(input int sel, input logic [15:0] expbits, input int n, input string name);
    logic act;
    for (int k = 0; k < n; k++) begin
      tick((k == 0) ? 5 : 10);
      act = (sel == 0) ? a_tx : b_tx;
      check($sformatf("%s bit%0d", name, k), act, expbits[k]);
    end
  endtask

  // sel 0 drives DUT A rx, otherwise DUT C; rd_cyc raises a_rx_rd for that one cycle.
  task automatic send_frame(input int sel, input logic [7:0] data, input logic par_en,
                            input logic par, input logic stopv, input int rd_cyc);
    logic bits[11];
    int   nb;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = data[i];
    nb = 9;
    if (par_en) begin
      bits[nb] = par;
      nb++;
    end
    bits[nb] = stopv;
    nb++;
    for (int c = 0; c < nb * 10; c++) begin
      if (sel == 0) a_rx = bits[c/10];
      else c_rx = bits[c/10];
      a_rx_rd = (c == rd_cyc);
      tick();
    end
    a_rx = 1'b1;
    c_rx = 1'b1;
    a_rx_rd = 1'b0;
    tick(4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tx_tab[0] = '{8'hA5, 16'h034A};
    tx_tab[1] = '{8'h3C, 16'h0278};
    rx_tab[0] = '{8'h11, 3'd1, 1'b0, 1'b0};
    rx_tab[1] = '{8'h22, 3'd2, 1'b1, 1'b0};
    rx_tab[2] = '{8'h33, 3'd3, 1'b1, 1'b0};
    rx_tab[3] = '{8'h44, 3'd4, 1'b1, 1'b0};
    rx_tab[4] = '{8'h55, 3'd4, 1'b1, 1'b1};
    drain_tab[0] = 8'h22; drain_tab[1] = 8'h33; drain_tab[2] = 8'h44; drain_tab[3] = 8'h66;

    a_n_rst = 0; bc_n_rst = 0;
    a_tx_data = 0; a_tx_wr = 0; a_rx_rd = 0; a_err_clr = 0; a_cts_n = 0; a_rx = 1;
    b_tx_data = 0; b_tx_wr = 0; b_rx_rd = 0; b_err_clr = 0; b_cts_n = 0;
    c_tx_data = 0; c_tx_wr = 0; c_rx_rd = 0; c_err_clr = 0; c_cts_n = 0; c_rx = 1;
    tick(3);

    check("rst tx", a_tx, 1'b1);
    check("rst busy", a_busy, 1'b0);
    check("rst rts_n", a_rts_n, 1'b0);
    check("rst perr", a_perr, 1'b0);
    check("rst ferr", a_ferr, 1'b0);
    check("rst ovr", a_ovr, 1'b0);
    check("rst tx_full", a_tx_full, 1'b0);
    check("rst rx_empty", a_rx_empty, 1'b1);
    check("rst tx_level", a_tx_level, 3'd0);
    check("rst rx_level", a_rx_level, 3'd0);
    check("rst b tx", b_tx, 1'b1);
    check("rst c rx_empty", c_rx_empty, 1'b1);
    a_n_rst = 1; bc_n_rst = 1;
    tick(2);

    // 8N1 back-to-back frames
    a_tx_data = tx_tab[0].word; a_tx_wr = 1;
    tick();
    check("wr level", a_tx_level, 3'd1);
    check("wr tx still idle", a_tx, 1'b1);
    a_tx_data = tx_tab[1].word;
    tick();
    a_tx_wr = 0;
    check("start tx low", a_tx, 1'b0);
    check("start busy", a_busy, 1'b1);
    check("start level", a_tx_level, 3'd1);
    for (int i = 0; i < 2; i++) begin
      if (i == 1) begin
        tick(5);
        check("gap tx", a_tx, 1'b1);
        check("gap busy", a_busy, 1'b0);
        tick();
        check("f2 tx low", a_tx, 1'b0);
        check("f2 level", a_tx_level, 3'd0);
      end
      check_frame(0, tx_tab[i].bits, 10, $sformatf("txf%0d", i));
    end
    tick(4);
    check("last stop busy", a_busy, 1'b1);
    tick();
    check("end busy", a_busy, 1'b0);
    check("end tx", a_tx, 1'b1);

    // cts_n gating, full FIFO, cts rise mid-frame, reset mid-frame
    a_cts_n = 1; a_tx_wr = 1;
    a_tx_data = 8'h5A; tick();
    a_tx_data = 8'hC3; tick();
    a_tx_data = 8'h01; tick();
    a_tx_data = 8'h02; tick();
    check("full flag", a_tx_full, 1'b1);
    a_tx_data = 8'h03; tick();
    a_tx_wr = 0;
    tick(20);
    check("cts hold tx", a_tx, 1'b1);
    check("cts hold busy", a_busy, 1'b0);
    check("cts hold level", a_tx_level, 3'd4);
    a_cts_n = 0;
    tick();
    check("cts go tx", a_tx, 1'b0);
    check("cts go busy", a_busy, 1'b1);
    check("cts go level", a_tx_level, 3'd3);
    tick(30);
    a_cts_n = 1;
    tick(20);
    check("cts mid busy", a_busy, 1'b1);
    check("cts mid bit", a_tx, 1'b1);
    a_n_rst = 0;
    tick();
    check("mid rst tx", a_tx, 1'b1);
    check("mid rst level", a_tx_level, 3'd0);
    check("mid rst busy", a_busy, 1'b0);
    a_n_rst = 1; a_cts_n = 0;
    tick(2);

    // frame error, then glitch rejection
    send_frame(0, 8'h96, 1'b0, 1'b0, 1'b0, -1);
    check("ferr set", a_ferr, 1'b1);
    check("ferr empty", a_rx_empty, 1'b1);
    check("ferr no perr", a_perr, 1'b0);
    a_err_clr = 1; tick(); a_err_clr = 0;
    check("ferr clr", a_ferr, 1'b0);
    a_rx = 0; tick(3); a_rx = 1;
    tick(30);
    check("glitch empty", a_rx_empty, 1'b1);
    check("glitch level", a_rx_level, 3'd0);
    check("glitch ferr", a_ferr, 1'b0);

    // fill the RX FIFO past depth
    for (int i = 0; i < 5; i++) begin
      send_frame(0, rx_tab[i].word, 1'b0, 1'b0, 1'b1, -1);
      check($sformatf("ovf%0d level", i), a_rx_level, rx_tab[i].level);
      check($sformatf("ovf%0d rts_n", i), a_rts_n, rx_tab[i].rts_n);
      check($sformatf("ovf%0d overrun", i), a_ovr, rx_tab[i].ovr);
    end
    check("ovf head", a_rx_data, 8'h11);
    send_frame(0, 8'h66, 1'b0, 1'b0, 1'b1, 97);
    check("full rd+push level", a_rx_level, 3'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d", i), a_rx_data, drain_tab[i]);
      a_rx_rd = 1; tick(); a_rx_rd = 0;
    end
    check("drain empty", a_rx_empty, 1'b1);
    tick();
    check("drain rts_n", a_rts_n, 1'b0);

    // 7E2 loopback
    b_tx_data = 7'h41; b_tx_wr = 1; tick(); b_tx_wr = 0;
    tick();
    check("b start", b_tx, 1'b0);
    check_frame(1, 16'h0682, 11, "b7e2");
    tick(4);
    check("b busy last", b_busy, 1'b1);
    tick();
    check("b busy end", b_busy, 1'b0);
    check("b rx_empty", b_rx_empty, 1'b0);
    check("b rx_data", b_rx_data, 7'h41);
    check("b perr", b_perr, 1'b0);
    check("b ferr", b_ferr, 1'b0);
    check("b ovr", b_ovr, 1'b0);

    // 8O1 wrong then right parity
    send_frame(2, 8'h55, 1'b1, 1'b0, 1'b1, -1);
    check("c perr set", c_perr, 1'b1);
    check("c perr empty", c_rx_empty, 1'b1);
    check("c perr ferr", c_ferr, 1'b0);
    c_err_clr = 1; tick(); c_err_clr = 0;
    check("c perr clr", c_perr, 1'b0);
    send_frame(2, 8'h55, 1'b1, 1'b1, 1'b1, -1);
    check("c good empty", c_rx_empty, 1'b0);
    check("c good data", c_rx_data, 8'h55);
    check("c good perr", c_perr, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
